// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - shared direction constants and modulo next-count helper for jk_mod_counter
package jk_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // In-range states wrap at the modulus.
  // Out-of-range states step in plain binary; the caller truncates to WIDTH,
  // so the up path eventually rolls over to 0.
  function automatic int unsigned mod_next(input int unsigned cur,
                                           input logic        up,
                                           input int unsigned modulus);
    if (cur >= modulus) begin
      if (up == DIR_UP) return cur + 1;
      else              return cur - 1;
    end
    if (up == DIR_UP) return (cur == modulus - 1) ? 0 : cur + 1;
    else              return (cur == 0) ? modulus - 1 : cur - 1;
  endfunction

endpackage

// File: rtl/jk_bit_ff.sv
// rtl/jk_bit_ff.sv - single JK flip-flop with synchronous active-high reset to a per-instance value
module jk_bit_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic equation: Q+ = J&~Q | ~K&Q
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= (j & ~q) | (~k & q);
  end

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter on JK bit cells; optional JK_MOD_COUNTER_LOCKOUT_EN traps illegal states
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MOD     = 6,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RST_VAL);
  localparam int unsigned      MOD_U    = MOD;
  localparam int unsigned      LAST     = MOD - 1;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

`ifdef JK_MOD_COUNTER_LOCKOUT_EN
  logic err_set;

  // Desired next value; illegal loads and illegal states are steered back to RST_VAL
  always_comb begin
    nxt     = q;
    err_set = 1'b0;
    if (load) begin
      if (32'(load_val) >= MOD_U) begin
        nxt     = RST_BITS;
        err_set = 1'b1;
      end else begin
        nxt = load_val;
      end
    end else if (en) begin
      if (32'(q) >= MOD_U) begin
        nxt     = RST_BITS;
        err_set = 1'b1;
      end else begin
        nxt = WIDTH'(mod_next(32'(q), dir, MOD_U));
      end
    end
  end

  // err is a one-cycle pulse following any lockout event
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_set;
  end
`else
  // Desired next value; loads are taken verbatim and out-of-range states count in binary
  always_comb begin
    nxt = q;
    if (load)    nxt = load_val;
    else if (en) nxt = WIDTH'(mod_next(32'(q), dir, MOD_U));
  end

  assign err = 1'b0;
`endif

  // Translate the desired value into JK drive: set bits that must rise, clear bits that must fall
  always_comb begin
    j = nxt & ~q;
    k = ~nxt & q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit_ff #(.RST_VAL(RST_BITS[i])) u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  assign state = q;

  // Terminal count: high in the cycle before a wrap edge, never in out-of-range states
  always_comb begin
    tc = en & ~load & ~rst &
         ((dir & (32'(q) == LAST)) | (~dir & (q == '0)));
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter with arithmetic reference model
module tb_jk_mod_counter;

  localparam int W  = 3;
  localparam int M  = 6;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         rst, en, dir, load;
  logic [W-1:0] load_val;
  logic [W-1:0] state;
  logic         tc, err;

  logic         sw_rst, sw_en, sw_dir;
  logic [W-1:0] sw_state [6];
  logic         sw_tc    [6];
  logic         sw_err   [6];
  logic [W-1:0] m8_state;
  logic         m8_tc, m8_err;

  int checks = 0;
  int errors = 0;
  int model;
  int model_err;

`ifdef JK_MOD_COUNTER_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MOD(M), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .state(state), .tc(tc), .err(err)
  );

  for (genvar g = 0; g < 6; g++) begin : g_sw
    jk_mod_counter #(.WIDTH(W), .MOD(6), .RST_VAL(g)) u_sw (
      .clk(clk), .rst(sw_rst), .en(sw_en), .dir(sw_dir), .load(1'b0),
      .load_val(3'd0), .state(sw_state[g]), .tc(sw_tc[g]), .err(sw_err[g])
    );
  end

  jk_mod_counter #(.WIDTH(W), .MOD(8), .RST_VAL(5)) u_m8 (
    .clk(clk), .rst(sw_rst), .en(sw_en), .dir(sw_dir), .load(1'b0),
    .load_val(3'd0), .state(m8_state), .tc(m8_tc), .err(m8_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: terminal count is high only when the enabled count is about to wrap
  function automatic int model_tc(input int s, input bit r, input bit e, input bit d, input bit l);
    if (r || l || !e) return 0;
    if (d && s == M - 1) return 1;
    if (!d && s == 0) return 1;
    return 0;
  endfunction

  // One clock step: drive, check tc mid-cycle, advance model, check registered outputs
  task automatic step(input bit r, input bit e, input bit d, input bit l,
                      input int lv, input string tag);
    int nstate;
    int nerr;
    rst = r; en = e; dir = d; load = l; load_val = W'(lv);
    @(negedge clk);
    check({tag, ".tc"}, 32'(tc), 32'(model_tc(model, r, e, d, l)));
    nstate = model;
    nerr   = 0;
    if (r) begin
      nstate = RV;
    end else if (l) begin
      if (LOCKOUT && lv >= M) begin nstate = RV; nerr = 1; end
      else nstate = lv;
    end else if (e) begin
      if (model >= M) begin
        if (LOCKOUT) begin nstate = RV; nerr = 1; end
        else nstate = d ? (model + 1) % (1 << W) : model - 1;
      end else begin
        nstate = d ? (model + 1) % M : (model + M - 1) % M;
      end
    end
    @(posedge clk);
    #1;
    model     = nstate;
    model_err = nerr;
    check({tag, ".state"}, 32'(state), 32'(model));
    check({tag, ".err"},   32'(err),   32'(model_err));
  endtask

  initial begin
    model = RV; model_err = 0;
    sw_rst = 1'b1; sw_en = 1'b0; sw_dir = 1'b1;

    // Reset for two cycles
    step(1, 1, 1, 1, 3, "reset0");
    step(1, 0, 1, 0, 0, "reset1");
    check("reset.state_is_rv", 32'(state), 32'(RV));

    // Count up through wrap: 1,2,3,4,5,0,1,2 after the reset value 0
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, "up");

    // Load 2 then count down through wrap
    step(0, 0, 0, 1, 2, "load2");
    check("load2.abs", 32'(state), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, "down");
    check("down.abs", 32'(state), 32'd4);

    // Load beats enable; reset beats load
    step(0, 1, 1, 1, 4, "load_wins");
    step(0, 0, 1, 1, 3, "load3");
    step(1, 1, 1, 1, 5, "rst_wins");
    check("rst_wins.abs", 32'(state), 32'd0);

    // Enable gating and a mid-sequence direction flip
    step(0, 0, 1, 1, 1, "load1");
    step(0, 1, 1, 0, 0, "en1");
    step(0, 0, 1, 0, 0, "en0a");
    step(0, 0, 1, 0, 0, "en0b");
    step(0, 1, 1, 0, 0, "en1b");
    check("en_gate.abs", 32'(state), 32'd3);
    step(0, 1, 0, 0, 0, "dirflip");
    check("dirflip.abs", 32'(state), 32'd2);

    // Out-of-range load handling
    step(0, 0, 1, 1, 7, "load7");
    check("load7.abs", 32'(state), LOCKOUT ? 32'(RV) : 32'd7);
    check("load7.err", 32'(err), LOCKOUT ? 32'd1 : 32'd0);
    step(0, 1, 1, 0, 0, "oor_up1");
    check("oor_up1.err", 32'(err), 32'd0);
    step(0, 1, 1, 0, 0, "oor_up2");
    step(0, 0, 0, 1, 6, "load6");
    step(0, 1, 0, 0, 0, "oor_down");
    step(0, 1, 0, 0, 0, "oor_down2");

    // Randomized stimulus against the model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 7)), "rand");
    end

    // Sweep instances: every RST_VAL with MOD=6 and a MOD=8 build
    @(negedge clk);
    sw_rst = 1'b1; sw_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 6; g++) check("sweep.reset", 32'(sw_state[g]), 32'(g));
    check("m8.reset", 32'(m8_state), 32'd5);
    sw_rst = 1'b0; sw_dir = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 6; g++) check("sweep.up", 32'(sw_state[g]), 32'((g + i) % 6));
      check("m8.up", 32'(m8_state), 32'((5 + i) % 8));
    end
    sw_dir = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 6; g++) check("sweep.down", 32'(sw_state[g]), 32'((g + 2 - i + 12) % 6));
      check("m8.down", 32'(m8_state), 32'((5 - i + 8) % 8));
    end
    for (int g = 0; g < 6; g++) check("sweep.err", 32'(sw_err[g]), 32'd0);
    check("m8.err", 32'(m8_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised modulo-N up/down counter built from JK flip-flop bit cells. It is the general successor to the fixed 3-bit JK sequence counters in the lab designs.
- Adds width/modulus parameters, enable, synchronous load, direction control and a terminal-count flag.
- Used as a reusable sequencer/timebase wherever a JK-based state counter is needed.

Parameters:
- WIDTH, 3, number of state bits (1..16)
- MOD, 6, count modulus; legal states 0..MOD-1; 2 <= MOD <= 2**WIDTH
- RST_VAL, 0, state after reset; must be < MOD

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- en  input  1  count enable
- dir  input  1  1 = count up, 0 = count down
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value written on load
- state  output  WIDTH  current count, taken directly from the JK flip-flop Q outputs
- tc  output  1  terminal count, combinational
- err  output  1  illegal-load flag, registered

Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.

Behaviour:
- Reset:
  - rst=1 at a clk edge gives state=RST_VAL and err=0 next cycle.
  - rst overrides load and en.
  - A reset mid-count discards the count immediately.
- Priority at each edge: rst > load > en > hold.
- Load:
  - load=1 gives state=load_val next cycle, regardless of en and dir.
  - Out-of-range handling is defined under Optional Feature.
- Count (en=1, load=0):
  - dir=1: state+1; at MOD-1 wraps to 0.
  - dir=0: state-1; at 0 wraps to MOD-1.
- Hold (en=0, load=0): state unchanged.
- tc = en & ~load & ((dir & state==MOD-1) | (~dir & state==0)). It is high in the cycle before the wrap edge. tc=0 whenever rst=1.
- Bit-cell drive:
  - For each bit i with desired next value n_i: J_i = n_i & ~Q_i, K_i = ~n_i & Q_i. Hold is J=K=0.
  - All next-state logic is expressed through J/K; no direct D assignment of state.
- Out-of-range states (state >= MOD, reachable only by load when the macro is absent):
  - up: plain binary +1 modulo 2**WIDTH, so it eventually reaches 0;
  - down: binary -1;
  - tc=0 in these states.
- dir change takes effect on the next enabled edge. There is no extra latency.
- Latency: all state changes are one clock after the qualifying edge.

Optional Feature:
- Macro: JK_MOD_COUNTER_LOCKOUT_EN
- Defined:
  - A load with load_val >= MOD loads RST_VAL instead.
  - err=1 for exactly the following cycle, then returns to 0 unless another illegal load occurs.
  - Any state >= MOD seen while en=1 (e.g. an upset) forces RST_VAL next cycle and pulses err.
  - The counter never remains outside 0..MOD-1.
- Undefined:
  - load_val is loaded unconditionally and out-of-range behaviour follows the Behaviour section.
  - err is tied to 0.

Decomposition:
- Shared package jk_counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0 constants;
  - helper function for the modulo next-count.
- One natural sub-module, jk_bit_ff: a single JK flip-flop with synchronous active-high rst to a per-instance reset value, J/K inputs and Q output.
  - Q+ = J&~Q | ~K&Q.
  - WIDTH instances are generated.

Test Plan (WIDTH=3, MOD=6, RST_VAL=0 unless noted):
- rst high 2 cycles, then en=1, dir=1 for 8 cycles -> state 0,1,2,3,4,5,0,1; tc=1 only while state=5.
- load=1, load_val=2, then en=1, dir=0 for 4 cycles -> state 2,1,0,5,4; tc=1 only while state=0.
- en=1 with load=1 and load_val=4 in the same cycle -> state=4 (load wins); assert rst at state=3 with load=1 -> state=0 next cycle.
- en toggled 1,0,0,1 from state 1 with dir=1 -> state 2,2,2,3; dir flipped mid-sequence at state 3 -> next enabled edge gives 2.
- Macro absent: load_val=7, en=1, dir=1 -> state 7,0,1, err=0. Macro defined: load_val=7 -> state=0, err=1 for one cycle, then 0.
- Sweep every RST_VAL 0..5 and MOD=8, WIDTH=3 build: full up and down cycle returns to start after 8 edges; no state ever >= MOD.
